// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART: FSM state encodings and the
// clock-to-oversample divider calculation.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_BREAK
    } rx_state_t;

    typedef enum logic [2:0] {
        TX_IDLE,
        TX_START,
        TX_DATA,
        TX_PARITY,
        TX_STOP
    } tx_state_t;

    function automatic int unsigned calc_divider(input int unsigned clock_rate,
                                                 input int unsigned baud_rate,
                                                 input int unsigned oversample);
        return clock_rate / (baud_rate * oversample);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Free-running oversample divider; tick is a one-cycle enable every DIVIDER clocks,
// first asserted DIVIDER cycles after reset.
module uart_baud_tick
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 32000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_BITS   = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int unsigned DIVIDER = calc_divider(CLOCK_RATE, BAUD_RATE, OVERSAMPLE);
    localparam logic [DIV_BITS-1:0] DIV_LAST = DIV_BITS'(DIVIDER - 1);

    logic [DIV_BITS-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            tick  <= 1'b0;
        end else if (count == DIV_LAST) begin
            count <= '0;
            tick  <= 1'b1;
        end else begin
            count <= count + 1'b1;
            tick  <= 1'b0;
        end
    end

endmodule

// File: rtl/uart_param.sv
// Parametrised single-clock full-duplex UART sharing one oversample tick.
// Define UART_PARITY_EN to add a parity bit after the data on TX and RX.
module uart_param
    import uart_pkg::*;
#(
    parameter int unsigned CLOCK_RATE = 32000000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned DIV_BITS   = 16,
    parameter int unsigned PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic                 tx,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err
);

    localparam int unsigned   TW       = $clog2(OVERSAMPLE);
    localparam logic [TW-1:0] OS_LAST  = TW'(OVERSAMPLE - 1);
    localparam logic [TW-1:0] MID_LAST = TW'(OVERSAMPLE / 2 - 2);
    localparam logic [3:0]    DB_LAST  = 4'(DATA_BITS - 1);
    localparam logic [3:0]    SB_LAST  = 4'(STOP_BITS - 1);

    if (OVERSAMPLE < 8 || OVERSAMPLE % 2 != 0 || DATA_BITS < 5 || DATA_BITS > 9 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD > 1) begin : g_param_check
        $error("uart_param: unsupported parameter combination");
    end

    logic tick;

    uart_baud_tick #(
        .CLOCK_RATE(CLOCK_RATE),
        .BAUD_RATE (BAUD_RATE),
        .OVERSAMPLE(OVERSAMPLE),
        .DIV_BITS  (DIV_BITS)
    ) u_baud_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    logic rx_meta, rx_s;

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end

    rx_state_t            rx_state, rx_next;
    logic [TW-1:0]        rx_ticks;
    logic [3:0]           rx_bits;
    logic [DATA_BITS-1:0] rx_shift;
    logic                 rx_bit_end, rx_shift_en, rx_done;
`ifdef UART_PARITY_EN
    logic                 rx_par_en;
`endif

    assign rx_bit_end = tick && (rx_ticks == OS_LAST);

    always_ff @(posedge clk) begin
        if (rst) rx_state <= RX_IDLE;
        else     rx_state <= rx_next;
    end

    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:   if (tick && !rx_s) rx_next = RX_START;
            RX_START:  if (tick && rx_ticks == MID_LAST) rx_next = rx_s ? RX_IDLE : RX_DATA;
`ifdef UART_PARITY_EN
            RX_DATA:   if (rx_bit_end && rx_bits == DB_LAST) rx_next = RX_PARITY;
            RX_PARITY: if (rx_bit_end) rx_next = RX_STOP;
`else
            RX_DATA:   if (rx_bit_end && rx_bits == DB_LAST) rx_next = RX_STOP;
`endif
            RX_STOP:   if (rx_bit_end) rx_next = rx_s ? RX_IDLE : RX_BREAK;
            RX_BREAK:  if (tick && rx_s) rx_next = RX_IDLE;
            default:   rx_next = RX_IDLE;
        endcase
    end

    always_comb begin
        rx_shift_en = 1'b0;
        rx_done     = 1'b0;
`ifdef UART_PARITY_EN
        rx_par_en   = 1'b0;
`endif
        case (rx_state)
            RX_DATA:   rx_shift_en = rx_bit_end;
`ifdef UART_PARITY_EN
            RX_PARITY: rx_par_en   = rx_bit_end;
`endif
            RX_STOP:   rx_done     = rx_bit_end;
            default:   ;
        endcase
    end

    // Tick counter restarts on every state change so each bit window is aligned to its entry tick.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_ticks  <= '0;
            rx_bits   <= '0;
            rx_shift  <= '0;
            rx_data   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            if (rx_state != rx_next || rx_bit_end) rx_ticks <= '0;
            else if (tick)                         rx_ticks <= rx_ticks + 1'b1;
            if (rx_state != RX_DATA) rx_bits <= '0;
            else if (rx_shift_en)    rx_bits <= rx_bits + 1'b1;
            if (rx_shift_en) rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
            if (rx_done) begin
                rx_data   <= rx_shift;
                rx_valid  <= rx_s;
                frame_err <= !rx_s;
            end
        end
    end

    tx_state_t            tx_state, tx_next;
    logic [TW-1:0]        tx_ticks;
    logic [3:0]           tx_bits;
    logic [DATA_BITS-1:0] tx_shift;
    logic                 tx_pending, tx_bit_end, tx_accept, tx_line;
`ifdef UART_PARITY_EN
    logic                 tx_par;
`endif

    assign tx_bit_end = tick && (tx_ticks == OS_LAST);
    assign tx_accept  = tx_valid && tx_ready;

    always_ff @(posedge clk) begin
        if (rst) tx_state <= TX_IDLE;
        else     tx_state <= tx_next;
    end

    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:   if (tick && tx_pending) tx_next = TX_START;
            TX_START:  if (tx_bit_end) tx_next = TX_DATA;
`ifdef UART_PARITY_EN
            TX_DATA:   if (tx_bit_end && tx_bits == DB_LAST) tx_next = TX_PARITY;
            TX_PARITY: if (tx_bit_end) tx_next = TX_STOP;
`else
            TX_DATA:   if (tx_bit_end && tx_bits == DB_LAST) tx_next = TX_STOP;
`endif
            TX_STOP:   if (tx_bit_end && tx_bits == SB_LAST) tx_next = TX_IDLE;
            default:   tx_next = TX_IDLE;
        endcase
    end

    always_comb begin
        tx_ready = (tx_state == TX_IDLE) && !tx_pending;
        tx_line  = 1'b1;
        case (tx_state)
            TX_START:  tx_line = 1'b0;
            TX_DATA:   tx_line = tx_shift[0];
`ifdef UART_PARITY_EN
            TX_PARITY: tx_line = tx_par;
`endif
            default:   tx_line = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tx         <= 1'b1;
            tx_pending <= 1'b0;
            tx_ticks   <= '0;
            tx_bits    <= '0;
            tx_shift   <= '0;
        end else begin
            tx <= tx_line;
            if (tx_accept) begin
                tx_shift   <= tx_data;
                tx_pending <= 1'b1;
            end
            if (tx_state == TX_IDLE && tx_next == TX_START) tx_pending <= 1'b0;
            if (tx_state != tx_next || tx_bit_end) tx_ticks <= '0;
            else if (tick)                         tx_ticks <= tx_ticks + 1'b1;
            if (tx_state != tx_next) tx_bits <= '0;
            else if (tx_bit_end)     tx_bits <= tx_bits + 1'b1;
            if (tx_state == TX_DATA && tx_bit_end) tx_shift <= {1'b0, tx_shift[DATA_BITS-1:1]};
        end
    end

`ifdef UART_PARITY_EN
    localparam logic PAR_ODD = PARITY_ODD[0];
    logic rx_par_bad;

    // Parity mismatch is held from the PARITY sample and reported alongside the stop decision.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_par     <= 1'b0;
            rx_par_bad <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            if (tx_accept) tx_par     <= (^tx_data) ^ PAR_ODD;
            if (rx_par_en) rx_par_bad <= rx_s ^ (^rx_shift) ^ PAR_ODD;
            parity_err <= rx_done && rx_par_bad;
        end
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule
